// File: rtl/vcache_stat_trigger.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module : vcache_stat_trigger                                           |
// | Brief  : Tracks in-flight vcache requests in order and pulses a stat   |
// |          print when a store to the print address retires.             |
// | Rev    : 1.0  initial release                                          |
// +------------------------------------------------------------------------+
module vcache_stat_trigger #(
    parameter int                      addr_width_p      = 32,
    parameter int                      data_width_p      = 32,
    parameter logic [addr_width_p-1:0] print_stat_addr_p = '0,
    parameter int                      els_p             = 4
) (
    input  logic                    clk_i,
    input  logic                    reset_i,

    input  logic                    pkt_v_i,
    input  logic                    pkt_yumi_i,
    input  logic                    pkt_write_i,
    input  logic [addr_width_p-1:0] pkt_addr_i,
    input  logic [data_width_p-1:0] pkt_data_i,

    input  logic                    v_i,
    input  logic                    yumi_i,

    output logic [31:0]             global_ctr_o,
    output logic                    print_stat_v_o,
    output logic [data_width_p-1:0] print_stat_tag_o,
    output logic                    overflow_o,
    output logic                    underflow_o
);

    localparam int                 c_PTR_W = (els_p > 1) ? $clog2(els_p) : 1;
    localparam int                 c_CNT_W = $clog2(els_p + 1);
    localparam logic [c_CNT_W-1:0] c_FULL  = c_CNT_W'(els_p);
    localparam logic [c_PTR_W-1:0] c_LAST  = c_PTR_W'(els_p - 1);

    logic [c_PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [c_PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [c_CNT_W-1:0]      count_q, count_d;
    logic [els_p-1:0]        is_print_q;
    logic [data_width_p-1:0] tag_mem_q [els_p];

    logic [31:0]             global_ctr_q;
    logic                    print_v_q, print_v_d;
    logic [data_width_p-1:0] print_tag_q, print_tag_d;
    logic                    overflow_q, overflow_d;
    logic                    underflow_q, underflow_d;

    logic accept_w, retire_w, empty_w, full_w, pop_w, push_w, is_print_w;

    always_comb begin
        accept_w   = pkt_v_i & pkt_yumi_i;
        retire_w   = v_i & yumi_i;
        empty_w    = (count_q == '0);
        full_w     = (count_q == c_FULL);
        pop_w      = retire_w & ~empty_w;
        // A pop in the same cycle frees the slot, so a full queue still takes the push.
        push_w     = accept_w & (~full_w | pop_w);
        is_print_w = pkt_write_i & (pkt_addr_i == print_stat_addr_p);
    end

    always_comb begin
        rd_ptr_d    = rd_ptr_q;
        wr_ptr_d    = wr_ptr_q;
        count_d     = count_q;
        print_v_d   = 1'b0;
        print_tag_d = print_tag_q;
        overflow_d  = overflow_q | (accept_w & full_w & ~pop_w);
        underflow_d = underflow_q | (retire_w & empty_w);

        if (pop_w) begin
            rd_ptr_d = (rd_ptr_q == c_LAST) ? '0 : rd_ptr_q + 1'b1;
            if (is_print_q[rd_ptr_q]) begin
                print_v_d   = 1'b1;
                print_tag_d = tag_mem_q[rd_ptr_q];
            end
        end
        if (push_w) begin
            wr_ptr_d = (wr_ptr_q == c_LAST) ? '0 : wr_ptr_q + 1'b1;
        end
        count_d = count_q + c_CNT_W'(push_w) - c_CNT_W'(pop_w);
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            rd_ptr_q     <= '0;
            wr_ptr_q     <= '0;
            count_q      <= '0;
            global_ctr_q <= '0;
            print_v_q    <= 1'b0;
            print_tag_q  <= '0;
            overflow_q   <= 1'b0;
            underflow_q  <= 1'b0;
        end else begin
            rd_ptr_q     <= rd_ptr_d;
            wr_ptr_q     <= wr_ptr_d;
            count_q      <= count_d;
            global_ctr_q <= global_ctr_q + 32'd1;
            print_v_q    <= print_v_d;
            print_tag_q  <= print_tag_d;
            overflow_q   <= overflow_d;
            underflow_q  <= underflow_d;
        end
    end

    // Entry storage needs no reset: a slot is only read after it has been written.
    always_ff @(posedge clk_i) begin
        if (!reset_i && push_w) begin
            is_print_q[wr_ptr_q] <= is_print_w;
            tag_mem_q[wr_ptr_q]  <= pkt_data_i;
        end
    end

    assign global_ctr_o     = global_ctr_q;
    assign print_stat_v_o   = print_v_q;
    assign print_stat_tag_o = print_tag_q;
    assign overflow_o       = overflow_q;
    assign underflow_o      = underflow_q;

endmodule
`default_nettype wire

// File: tb/tb_vcache_stat_trigger.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module : tb_vcache_stat_trigger                                        |
// | Brief  : Directed and random bench against an in-order queue model.    |
// | Rev    : 1.0  initial release                                          |
// +------------------------------------------------------------------------+
module tb_vcache_stat_trigger;

    localparam int              AW  = 16;
    localparam int              DW  = 16;
    localparam int              ELS = 4;
    localparam logic [AW-1:0]   PA  = 16'h0040;

    logic          clk = 1'b0;
    logic          reset_i = 1'b1;
    logic          pkt_v_i = 1'b0, pkt_yumi_i = 1'b0, pkt_write_i = 1'b0;
    logic [AW-1:0] pkt_addr_i = '0;
    logic [DW-1:0] pkt_data_i = '0;
    logic          v_i = 1'b0, yumi_i = 1'b0;
    logic [31:0]   global_ctr_o;
    logic          print_stat_v_o;
    logic [DW-1:0] print_stat_tag_o;
    logic          overflow_o, underflow_o;

    vcache_stat_trigger #(
        .addr_width_p     (AW),
        .data_width_p     (DW),
        .print_stat_addr_p(PA),
        .els_p            (ELS)
    ) dut (
        .clk_i           (clk),
        .reset_i         (reset_i),
        .pkt_v_i         (pkt_v_i),
        .pkt_yumi_i      (pkt_yumi_i),
        .pkt_write_i     (pkt_write_i),
        .pkt_addr_i      (pkt_addr_i),
        .pkt_data_i      (pkt_data_i),
        .v_i             (v_i),
        .yumi_i          (yumi_i),
        .global_ctr_o    (global_ctr_o),
        .print_stat_v_o  (print_stat_v_o),
        .print_stat_tag_o(print_stat_tag_o),
        .overflow_o      (overflow_o),
        .underflow_o     (underflow_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic          p;
        logic [DW-1:0] tag;
    } entry_t;

    entry_t        mq[$];
    logic          exp_v   = 1'b0;
    logic [DW-1:0] exp_tag = '0;
    logic          exp_ovf = 1'b0, exp_unf = 1'b0;
    logic [31:0]   exp_ctr = '0;
    int            n_checks = 0, n_fail = 0, pulse_cnt = 0;

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h t=%0t", name, obs, exp, $time);
        end
    endtask

    // One clock: drive inputs, advance model on the edge, compare just after it.
    task automatic step(input logic rst, input logic pv, input logic py, input logic wr,
                        input logic [AW-1:0] addr, input logic [DW-1:0] data,
                        input logic rv, input logic ry);
        int pre;
        logic popped;
        reset_i = rst; pkt_v_i = pv; pkt_yumi_i = py; pkt_write_i = wr;
        pkt_addr_i = addr; pkt_data_i = data; v_i = rv; yumi_i = ry;
        @(posedge clk);
        if (rst) begin
            mq.delete();
            exp_v = 0; exp_tag = '0; exp_ovf = 0; exp_unf = 0; exp_ctr = '0;
        end else begin
            exp_ctr = exp_ctr + 32'd1;
            exp_v   = 1'b0;
            pre     = mq.size();
            popped  = 1'b0;
            if (rv && ry) begin
                if (pre == 0) exp_unf = 1'b1;
                else begin
                    entry_t e;
                    e = mq.pop_front();
                    popped = 1'b1;
                    if (e.p) begin exp_v = 1'b1; exp_tag = e.tag; end
                end
            end
            if (pv && py) begin
                if (pre < ELS || popped) mq.push_back({wr && (addr == PA), data});
                else exp_ovf = 1'b1;
            end
        end
        #1;
        if (print_stat_v_o === 1'b1) pulse_cnt++;
        chk("print_v",   {31'd0, print_stat_v_o}, {31'd0, exp_v});
        chk("print_tag", {16'd0, print_stat_tag_o}, {16'd0, exp_tag});
        chk("overflow",  {31'd0, overflow_o}, {31'd0, exp_ovf});
        chk("underflow", {31'd0, underflow_o}, {31'd0, exp_unf});
        chk("global_ctr", global_ctr_o, exp_ctr);
    endtask

    task automatic idle();
        step(0, 0, 0, 0, '0, '0, 0, 0);
    endtask

    initial begin
        int pc0;

        // reset state
        repeat (3) step(1, 0, 0, 0, '0, '0, 0, 0);

        // single trigger, retired two cycles after accept
        step(0, 1, 1, 1, PA, 16'h002A, 0, 0);
        idle();
        step(0, 0, 0, 0, '0, '0, 1, 1);
        repeat (3) idle();

        // ordering: load, trigger 5, store, trigger 9, retire one per cycle
        step(0, 1, 1, 0, PA,      16'h0077, 0, 0);
        step(0, 1, 1, 1, PA,      16'h0005, 0, 0);
        step(0, 1, 1, 1, 16'h0044, 16'h0033, 0, 0);
        step(0, 1, 1, 1, PA,      16'h0009, 0, 0);
        repeat (4) step(0, 0, 0, 0, '0, '0, 1, 1);
        repeat (2) idle();

        // back-to-back accept and retire, triggers on even cycles
        pc0 = pulse_cnt;
        step(0, 1, 1, 0, 16'h0010, 16'h0000, 0, 0);
        for (int i = 0; i < 100; i++)
            step(0, 1, 1, (i % 2) == 0, PA, 16'(16'h1000 + i), 1, 1);
        step(0, 0, 0, 0, '0, '0, 1, 1);
        idle();
        chk("b2b_pulses", 32'(pulse_cnt - pc0), 32'd50);

        // overflow: five accepts into a four-deep queue, then drain
        for (int i = 1; i <= 5; i++) step(0, 1, 1, 1, PA, 16'(i), 0, 0);
        for (int i = 0; i < 4; i++)  step(0, 0, 0, 0, '0, '0, 1, 1);
        repeat (2) idle();

        // underflow, then reset with two entries in flight and a retire in the reset cycle
        step(1, 0, 0, 0, '0, '0, 0, 0);
        step(0, 0, 0, 0, '0, '0, 1, 1);
        step(0, 1, 1, 1, PA, 16'h00A1, 0, 0);
        step(0, 1, 1, 1, PA, 16'h00A2, 0, 0);
        step(1, 0, 0, 0, '0, '0, 1, 1);
        step(0, 0, 0, 0, '0, '0, 1, 1);
        // empty queue with simultaneous push: pop ignored, push kept
        step(0, 1, 1, 1, PA, 16'h00B3, 1, 1);
        step(0, 0, 0, 0, '0, '0, 1, 1);
        idle();

        // randomized traffic with occasional reset
        step(1, 0, 0, 0, '0, '0, 0, 0);
        for (int i = 0; i < 600; i++) begin
            logic [AW-1:0] a;
            a = ($urandom_range(0, 1) == 0) ? PA : AW'($urandom);
            step($urandom_range(0, 59) == 0,
                 1'($urandom), 1'($urandom), 1'($urandom), a, DW'($urandom),
                 1'($urandom), 1'($urandom));
        end

        // counter wrap
        step(1, 0, 0, 0, '0, '0, 0, 0);
        force dut.global_ctr_q = 32'hFFFF_FFFE;
        #1;
        release dut.global_ctr_q;
        exp_ctr = 32'hFFFF_FFFE;
        chk("ctr_preset", global_ctr_o, 32'hFFFF_FFFE);
        idle();
        chk("ctr_max", global_ctr_o, 32'hFFFF_FFFF);
        idle();
        chk("ctr_wrap", global_ctr_o, 32'h0000_0000);

        $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
